if_stage: RTL and testbench



---
 rtl/if_stage.sv | 103 ++++++++++
 tb/tb_if_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: PC register, sequential/branch next-PC select and the IF/ID register.
// imem_addr/pc_next_seq are combinational from the PC; everything else updates one edge later, holds on stall.
module if_stage #(
  parameter int unsigned             ADDR_WIDTH   = 64,
  parameter int unsigned             INSTR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]   RESET_PC     = '0,
  parameter int unsigned             PC_STEP      = 4,
  parameter int unsigned             OFFSET_WIDTH = 26,
  parameter int unsigned             COUNT_WIDTH  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [ADDR_WIDTH-1:0]   branch_pc,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  output logic [ADDR_WIDTH-1:0]   pc_next_seq,
  output logic [ADDR_WIDTH-1:0]   ifid_pc,
  output logic [INSTR_WIDTH-1:0]  ifid_instr,
  output logic                    ifid_valid,
  output logic [COUNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    ACT_BRANCH,
    ACT_STALL,
    ACT_ADVANCE
  } action_e;

  action_e                 action;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   ifid_pc_q, ifid_pc_d;
  logic [INSTR_WIDTH-1:0]  ifid_instr_q, ifid_instr_d;
  logic                    ifid_valid_q, ifid_valid_d;
  logic [COUNT_WIDTH-1:0]  fetch_count_q, fetch_count_d;
  logic [ADDR_WIDTH-1:0]   offset_ext;
  logic [ADDR_WIDTH-1:0]   branch_target;

  // Word offset is sign-extended to full address width before scaling to bytes.
  assign offset_ext    = {{(ADDR_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};
  assign branch_target = branch_pc + (offset_ext << 2);
  assign pc_next_seq   = pc_q + ADDR_WIDTH'(PC_STEP);
  assign imem_addr     = pc_q;

  // Redirect outranks stall so a taken branch is never lost behind a hazard hold.
  always_comb begin
    action = ACT_ADVANCE;
    if (branch_taken) begin
      action = ACT_BRANCH;
    end else if (stall) begin
      action = ACT_STALL;
    end
  end

  always_comb begin
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    case (action)
      ACT_BRANCH: begin
        pc_d         = branch_target;
        ifid_pc_d    = '0;
        ifid_instr_d = '0;
        ifid_valid_d = 1'b0;
      end
      ACT_ADVANCE: begin
        pc_d          = pc_next_seq;
        ifid_pc_d     = pc_q;
        ifid_instr_d  = imem_data;
        ifid_valid_d  = 1'b1;
        fetch_count_d = fetch_count_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: default-reset instance plus a RESET_PC = 0x1000 instance.
module tb_if_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_pc = '0;
  logic [25:0] branch_offset = '0;
  logic [63:0] imem_addr, pc_next_seq, ifid_pc;
  logic [31:0] imem_data, ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  logic        reset2 = 1'b1;
  logic [63:0] imem_addr2, pc_next_seq2, ifid_pc2;
  logic [31:0] imem_data2, ifid_instr2;
  logic        ifid_valid2;
  logic [31:0] fetch_count2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Instruction memory model: word at address A is 0x8B000000 + A.
  assign imem_data  = 32'h8B00_0000 + imem_addr[31:0];
  assign imem_data2 = 32'h8B00_0000 + imem_addr2[31:0];

  if_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset), .imem_addr(imem_addr),
    .imem_data(imem_data), .pc_next_seq(pc_next_seq), .ifid_pc(ifid_pc),
    .ifid_instr(ifid_instr), .ifid_valid(ifid_valid), .fetch_count(fetch_count)
  );

  if_stage #(.RESET_PC(64'h1000)) dut2 (
    .clock(clock), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_pc(64'h0), .branch_offset(26'h0), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .pc_next_seq(pc_next_seq2), .ifid_pc(ifid_pc2),
    .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2), .fetch_count(fetch_count2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 64'h0); end
    checks++; if (pc_next_seq !== 64'h4) begin errors++; $display("FAIL reset_pc_next_seq: got %h want %h", pc_next_seq, 64'h4); end
    checks++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h want %h", ifid_pc, 64'h0); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_ifid_instr: got %h want %h", ifid_instr, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid: got %b want 0", ifid_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fetch_count: got %0d want 0", fetch_count); end
    reset = 1'b0;
  endtask

  task automatic test_advance();
    for (int i = 1; i <= 4; i++) begin
      logic [63:0] exp_addr, exp_pc;
      logic [31:0] exp_instr;
      exp_addr  = 64'(4 * i);
      exp_pc    = 64'(4 * (i - 1));
      exp_instr = 32'h8B00_0000 + 32'(4 * (i - 1));
      step();
      checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL adv_imem_addr[%0d]: got %h want %h", i, imem_addr, exp_addr); end
      checks++; if (ifid_pc !== exp_pc) begin errors++; $display("FAIL adv_ifid_pc[%0d]: got %h want %h", i, ifid_pc, exp_pc); end
      checks++; if (ifid_instr !== exp_instr) begin errors++; $display("FAIL adv_ifid_instr[%0d]: got %h want %h", i, ifid_instr, exp_instr); end
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL adv_ifid_valid[%0d]: got %b want 1", i, ifid_valid); end
      checks++; if (fetch_count !== 32'(i)) begin errors++; $display("FAIL adv_fetch_count[%0d]: got %0d want %0d", i, fetch_count, i); end
    end
  endtask

  task automatic test_stall();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL stall_imem_addr[%0d]: got %h want %h", i, imem_addr, 64'h8); end
      checks++; if (ifid_pc !== 64'h4) begin errors++; $display("FAIL stall_ifid_pc[%0d]: got %h want %h", i, ifid_pc, 64'h4); end
      checks++; if (ifid_instr !== 32'h8B00_0004) begin errors++; $display("FAIL stall_ifid_instr[%0d]: got %h want %h", i, ifid_instr, 32'h8B00_0004); end
      checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_fetch_count[%0d]: got %0d want 2", i, fetch_count); end
    end
    stall = 1'b0;
    step();
    checks++; if (imem_addr !== 64'hC) begin errors++; $display("FAIL stall_resume_imem_addr: got %h want %h", imem_addr, 64'hC); end
    checks++; if (ifid_pc !== 64'h8) begin errors++; $display("FAIL stall_resume_ifid_pc: got %h want %h", ifid_pc, 64'h8); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL stall_resume_fetch_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_pc     = 64'h10;
    branch_offset = 26'h3FF_FFFE;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 64'h8) begin errors++; $display("FAIL br_imem_addr: got %h want %h", imem_addr, 64'h8); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_ifid_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL br_ifid_instr: got %h want %h", ifid_instr, 32'h0); end
    checks++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL br_ifid_pc: got %h want %h", ifid_pc, 64'h0); end
    checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL br_fetch_count: got %0d want 3", fetch_count); end
    step();
    checks++; if (imem_addr !== 64'hC) begin errors++; $display("FAIL br_next_imem_addr: got %h want %h", imem_addr, 64'hC); end
    checks++; if (ifid_pc !== 64'h8) begin errors++; $display("FAIL br_next_ifid_pc: got %h want %h", ifid_pc, 64'h8); end
    checks++; if (ifid_instr !== 32'h8B00_0008) begin errors++; $display("FAIL br_next_ifid_instr: got %h want %h", ifid_instr, 32'h8B00_0008); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL br_next_ifid_valid: got %b want 1", ifid_valid); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL br_next_fetch_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_branch_over_stall();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_pc     = 64'h20;
    branch_offset = 26'd5;
    step();
    stall        = 1'b0;
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 64'h34) begin errors++; $display("FAIL brst_imem_addr: got %h want %h", imem_addr, 64'h34); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL brst_ifid_valid: got %b want 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL brst_ifid_instr: got %h want %h", ifid_instr, 32'h0); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL brst_fetch_count: got %0d want 4", fetch_count); end
    step();
    checks++; if (ifid_pc !== 64'h34) begin errors++; $display("FAIL brst_next_ifid_pc: got %h want %h", ifid_pc, 64'h34); end
    checks++; if (imem_addr !== 64'h38) begin errors++; $display("FAIL brst_next_imem_addr: got %h want %h", imem_addr, 64'h38); end
    checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL brst_next_fetch_count: got %0d want 5", fetch_count); end
  endtask

  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_pc     = 64'h0;
    branch_offset = 26'h3FF_FFFF;
    step();
    branch_taken = 1'b0;
    checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_target: got %h want %h", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC); end
    checks++; if (pc_next_seq !== 64'h0) begin errors++; $display("FAIL wrap_pc_next_seq: got %h want %h", pc_next_seq, 64'h0); end
    step();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL wrap_imem_addr: got %h want %h", imem_addr, 64'h0); end
    checks++; if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_ifid_pc: got %h want %h", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC); end
    checks++; if (ifid_instr !== 32'h8AFF_FFFC) begin errors++; $display("FAIL wrap_ifid_instr: got %h want %h", ifid_instr, 32'h8AFF_FFFC); end
    checks++; if (fetch_count !== 32'd6) begin errors++; $display("FAIL wrap_fetch_count: got %0d want 6", fetch_count); end
  endtask

  task automatic test_reset_mid_stall();
    branch_taken  = 1'b1;
    branch_pc     = 64'h40;
    branch_offset = 26'd0;
    step();
    branch_taken = 1'b0;
    stall = 1'b1;
    step();
    checks++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL rst_stall_pre_imem_addr: got %h want %h", imem_addr, 64'h40); end
    reset = 1'b1;
    step();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_stall_imem_addr: got %h want %h", imem_addr, 64'h0); end
    checks++; if (ifid_pc !== 64'h0) begin errors++; $display("FAIL rst_stall_ifid_pc: got %h want %h", ifid_pc, 64'h0); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_stall_ifid_instr: got %h want %h", ifid_instr, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_stall_ifid_valid: got %b want 0", ifid_valid); end
    checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_stall_fetch_count: got %0d want 0", fetch_count); end
    branch_taken  = 1'b1;
    branch_pc     = 64'h80;
    step();
    checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_branch_imem_addr: got %h want %h", imem_addr, 64'h0); end
    reset        = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    step();
    checks++; if (imem_addr !== 64'h4) begin errors++; $display("FAIL rst_first_adv_imem_addr: got %h want %h", imem_addr, 64'h4); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rst_first_adv_ifid_valid: got %b want 1", ifid_valid); end
    checks++; if (ifid_instr !== 32'h8B00_0000) begin errors++; $display("FAIL rst_first_adv_ifid_instr: got %h want %h", ifid_instr, 32'h8B00_0000); end
    checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL rst_first_adv_fetch_count: got %0d want 1", fetch_count); end
  endtask

  task automatic test_reset_pc();
    checks++; if (imem_addr2 !== 64'h1000) begin errors++; $display("FAIL rpc_imem_addr: got %h want %h", imem_addr2, 64'h1000); end
    checks++; if (pc_next_seq2 !== 64'h1004) begin errors++; $display("FAIL rpc_pc_next_seq: got %h want %h", pc_next_seq2, 64'h1004); end
    checks++; if (ifid_valid2 !== 1'b0) begin errors++; $display("FAIL rpc_ifid_valid: got %b want 0", ifid_valid2); end
    reset2 = 1'b0;
    step();
    checks++; if (imem_addr2 !== 64'h1004) begin errors++; $display("FAIL rpc_adv_imem_addr: got %h want %h", imem_addr2, 64'h1004); end
    checks++; if (ifid_pc2 !== 64'h1000) begin errors++; $display("FAIL rpc_adv_ifid_pc: got %h want %h", ifid_pc2, 64'h1000); end
    checks++; if (ifid_instr2 !== 32'h8B00_1000) begin errors++; $display("FAIL rpc_adv_ifid_instr: got %h want %h", ifid_instr2, 32'h8B00_1000); end
    checks++; if (fetch_count2 !== 32'd1) begin errors++; $display("FAIL rpc_adv_fetch_count: got %0d want 1", fetch_count2); end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_wrap();
    test_reset_mid_stall();
    test_reset_pc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
